// File: rtl/skin_detect_pkg.sv
// Shared constants, FSM state type, config payload and channel expansion for skin_detect_bbox.
// Optional luma gating is compiled in with `define SKIN_LUMA_GATE_EN.
package skin_detect_pkg;

  localparam int unsigned PIPE_LAT = 4;

  localparam logic [15:0] K_Y_R  = 16'd77;
  localparam logic [15:0] K_Y_G  = 16'd150;
  localparam logic [15:0] K_Y_B  = 16'd29;
  localparam logic [15:0] K_CB_R = 16'd43;
  localparam logic [15:0] K_CB_G = 16'd85;
  localparam logic [15:0] K_CB_B = 16'd128;
  localparam logic [15:0] K_CR_R = 16'd128;
  localparam logic [15:0] K_CR_G = 16'd107;
  localparam logic [15:0] K_CR_B = 16'd21;
  localparam logic [15:0] K_OFS  = 16'd32768;

  typedef enum logic {
    ST_ARMING = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Classification bounds, captured once per frame
  typedef struct packed {
    logic [7:0] cb_min;
    logic [7:0] cb_max;
    logic [7:0] cr_min;
    logic [7:0] cr_max;
`ifdef SKIN_LUMA_GATE_EN
    logic [7:0] y_min;
    logic [7:0] y_max;
`endif
  } cfg_t;

  // Widen a w-bit channel (held in the low bits of c) to 8 bits by repeating it from the MSB down
  function automatic logic [7:0] expand8(input logic [7:0] c, input int unsigned w);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[3'(7 - i)] = c[3'(w - 1 - (i % w))];
    end
    return r;
  endfunction

endpackage

// File: rtl/skin_detect_bbox_if.sv
// Raw pixel stream bundle: frame syncs plus one RGB pixel per clock.
interface skin_detect_bbox_if #(
  parameter int unsigned R_W = 5,
  parameter int unsigned G_W = 6,
  parameter int unsigned B_W = 5
);
  logic           vsync;
  logic           href;
  logic           de;
  logic [R_W-1:0] red;
  logic [G_W-1:0] green;
  logic [B_W-1:0] blue;

  modport master (output vsync, href, de, red, green, blue);
  modport slave  (input  vsync, href, de, red, green, blue);
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// Three-stage RGB -> YCbCr (multiply, add, slice) with matching sync delay.
// The Y path exists only when SKIN_LUMA_GATE_EN is defined.
module rgb2ycbcr_pipe
  import skin_detect_pkg::*;
#(
  parameter int unsigned R_W = 5,
  parameter int unsigned G_W = 6,
  parameter int unsigned B_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  skin_detect_bbox_if.slave   pix,
`ifdef SKIN_LUMA_GATE_EN
  output logic [7:0]          y_o,
`endif
  output logic [7:0]          cb_o,
  output logic [7:0]          cr_o,
  output logic                vsync_o,
  output logic                href_o,
  output logic                de_o
);

  localparam int unsigned SYNC_D = PIPE_LAT - 1;

  logic [7:0] r8, g8, b8;
  always_comb begin
    r8 = expand8(8'(pix.red), R_W);
    g8 = expand8(8'(pix.green), G_W);
    b8 = expand8(8'(pix.blue), B_W);
  end

  logic [15:0] cbr_q, cbg_q, cbb_q, crr_q, crg_q, crb_q;
  logic [15:0] cb_sum_q, cr_sum_q;
  logic [7:0]  cb_q, cr_q;
  logic [SYNC_D-1:0] vs_sr_q, hs_sr_q, de_sr_q;

  // Chroma products, sums mod 2^16, then the integer part
  always_ff @(posedge clk) begin
    if (rst) begin
      cbr_q    <= '0;
      cbg_q    <= '0;
      cbb_q    <= '0;
      crr_q    <= '0;
      crg_q    <= '0;
      crb_q    <= '0;
      cb_sum_q <= '0;
      cr_sum_q <= '0;
      cb_q     <= '0;
      cr_q     <= '0;
      vs_sr_q  <= '0;
      hs_sr_q  <= '0;
      de_sr_q  <= '0;
    end else begin
      cbr_q    <= K_CB_R * 16'(r8);
      cbg_q    <= K_CB_G * 16'(g8);
      cbb_q    <= K_CB_B * 16'(b8);
      crr_q    <= K_CR_R * 16'(r8);
      crg_q    <= K_CR_G * 16'(g8);
      crb_q    <= K_CR_B * 16'(b8);
      cb_sum_q <= cbb_q - cbr_q - cbg_q + K_OFS;
      cr_sum_q <= crr_q - crg_q - crb_q + K_OFS;
      cb_q     <= cb_sum_q[15:8];
      cr_q     <= cr_sum_q[15:8];
      vs_sr_q  <= {vs_sr_q[SYNC_D-2:0], pix.vsync};
      hs_sr_q  <= {hs_sr_q[SYNC_D-2:0], pix.href};
      de_sr_q  <= {de_sr_q[SYNC_D-2:0], pix.de};
    end
  end

`ifdef SKIN_LUMA_GATE_EN
  logic [15:0] yr_q, yg_q, yb_q, y_sum_q;
  logic [7:0]  y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      yr_q    <= '0;
      yg_q    <= '0;
      yb_q    <= '0;
      y_sum_q <= '0;
      y_q     <= '0;
    end else begin
      yr_q    <= K_Y_R * 16'(r8);
      yg_q    <= K_Y_G * 16'(g8);
      yb_q    <= K_Y_B * 16'(b8);
      y_sum_q <= yr_q + yg_q + yb_q;
      y_q     <= y_sum_q[15:8];
    end
  end

  assign y_o = y_q;

  logic unused_frac;
  assign unused_frac = ^{cb_sum_q[7:0], cr_sum_q[7:0], y_sum_q[7:0]};
`else
  logic unused_frac;
  assign unused_frac = ^{cb_sum_q[7:0], cr_sum_q[7:0]};
`endif

  assign cb_o    = cb_q;
  assign cr_o    = cr_q;
  assign vsync_o = vs_sr_q[SYNC_D-1];
  assign href_o  = hs_sr_q[SYNC_D-1];
  assign de_o    = de_sr_q[SYNC_D-1];

endmodule

// File: rtl/skin_detect_bbox.sv
// Skin classifier with per-frame bounding box and pixel count over a delayed pixel stream.
// Define SKIN_LUMA_GATE_EN to also gate on luma (cfg_y_min/cfg_y_max).
module skin_detect_bbox
  import skin_detect_pkg::*;
#(
  parameter int unsigned R_W   = 5,
  parameter int unsigned G_W   = 6,
  parameter int unsigned B_W   = 5,
  parameter int unsigned X_W   = 11,
  parameter int unsigned Y_W   = 11,
  parameter int unsigned CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_href,
  input  logic             pre_frame_de,
  input  logic [R_W-1:0]   img_red,
  input  logic [G_W-1:0]   img_green,
  input  logic [B_W-1:0]   img_blue,
  input  logic [7:0]       cfg_cb_min,
  input  logic [7:0]       cfg_cb_max,
  input  logic [7:0]       cfg_cr_min,
  input  logic [7:0]       cfg_cr_max,
  input  logic [7:0]       cfg_y_min,
  input  logic [7:0]       cfg_y_max,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_de,
  output logic             skin_mask,
  output logic [X_W-1:0]   bbox_x_min,
  output logic [X_W-1:0]   bbox_x_max,
  output logic [Y_W-1:0]   bbox_y_min,
  output logic [Y_W-1:0]   bbox_y_max,
  output logic [CNT_W-1:0] skin_cnt,
  output logic             bbox_valid,
  output logic             frame_done
);

  skin_detect_bbox_if #(.R_W(R_W), .G_W(G_W), .B_W(B_W)) pix ();
  assign pix.vsync = pre_frame_vsync;
  assign pix.href  = pre_frame_href;
  assign pix.de    = pre_frame_de;
  assign pix.red   = img_red;
  assign pix.green = img_green;
  assign pix.blue  = img_blue;

  logic [7:0] cb3, cr3;
  logic       vs3, hs3, de3;
`ifdef SKIN_LUMA_GATE_EN
  logic [7:0] y3;
`endif

  rgb2ycbcr_pipe #(.R_W(R_W), .G_W(G_W), .B_W(B_W)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .pix     (pix),
`ifdef SKIN_LUMA_GATE_EN
    .y_o     (y3),
`endif
    .cb_o    (cb3),
    .cr_o    (cr3),
    .vsync_o (vs3),
    .href_o  (hs3),
    .de_o    (de3)
  );

  cfg_t cfg_d, shadow_q;
  always_comb begin
    cfg_d.cb_min = cfg_cb_min;
    cfg_d.cb_max = cfg_cb_max;
    cfg_d.cr_min = cfg_cr_min;
    cfg_d.cr_max = cfg_cr_max;
`ifdef SKIN_LUMA_GATE_EN
    cfg_d.y_min  = cfg_y_min;
    cfg_d.y_max  = cfg_y_max;
`endif
  end

`ifndef SKIN_LUMA_GATE_EN
  logic unused_cfg_y;
  assign unused_cfg_y = ^{cfg_y_min, cfg_y_max};
`endif

  state_e           state_q;
  logic             vs_q, hs_q, de_q, mask_q, done_q, valid_q;
  logic [X_W-1:0]   x_q, acc_x_min_q, acc_x_max_q, bx_min_q, bx_max_q;
  logic [Y_W-1:0]   y_q, acc_y_min_q, acc_y_max_q, by_min_q, by_max_q;
  logic [CNT_W-1:0] acc_cnt_q, cnt_q;
  logic             skin_d, vs_rise_d, de_fall_d;

  // Stage-3 events line up with the edge that makes them visible on post_*
  always_comb begin
    skin_d = de3 &&
             (cb3 > shadow_q.cb_min) && (cb3 < shadow_q.cb_max) &&
             (cr3 > shadow_q.cr_min) && (cr3 < shadow_q.cr_max);
`ifdef SKIN_LUMA_GATE_EN
    skin_d = skin_d && (y3 > shadow_q.y_min) && (y3 < shadow_q.y_max);
`endif
    vs_rise_d = vs3 && !vs_q;
    de_fall_d = !de3 && de_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARMING;
      shadow_q    <= '0;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      de_q        <= 1'b0;
      mask_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      acc_x_min_q <= '0;
      acc_x_max_q <= '0;
      acc_y_min_q <= '0;
      acc_y_max_q <= '0;
      acc_cnt_q   <= '0;
      bx_min_q    <= '0;
      bx_max_q    <= '0;
      by_min_q    <= '0;
      by_max_q    <= '0;
      cnt_q       <= '0;
    end else begin
      vs_q   <= vs3;
      hs_q   <= hs3;
      de_q   <= de3;
      mask_q <= skin_d;
      done_q <= 1'b0;

      if (vs_rise_d) begin
        x_q      <= '0;
        y_q      <= '0;
        shadow_q <= cfg_d;
      end else if (de3) begin
        if (x_q != '1) x_q <= x_q + X_W'(1);
      end else if (de_fall_d) begin
        x_q <= '0;
        if (y_q != '1) y_q <= y_q + Y_W'(1);
      end

      // Frame boundary wins over a coincident skin pixel
      if (vs_rise_d) begin
        if (state_q == ST_ACTIVE) begin
          bx_min_q <= acc_x_min_q;
          bx_max_q <= acc_x_max_q;
          by_min_q <= acc_y_min_q;
          by_max_q <= acc_y_max_q;
          cnt_q    <= acc_cnt_q;
          valid_q  <= (acc_cnt_q != '0);
          done_q   <= 1'b1;
        end
        state_q     <= ST_ACTIVE;
        acc_x_min_q <= '0;
        acc_x_max_q <= '0;
        acc_y_min_q <= '0;
        acc_y_max_q <= '0;
        acc_cnt_q   <= '0;
      end else if (skin_d) begin
        if (acc_cnt_q == '0) begin
          acc_x_min_q <= x_q;
          acc_x_max_q <= x_q;
          acc_y_min_q <= y_q;
          acc_y_max_q <= y_q;
        end else begin
          if (x_q < acc_x_min_q) acc_x_min_q <= x_q;
          if (x_q > acc_x_max_q) acc_x_max_q <= x_q;
          if (y_q < acc_y_min_q) acc_y_min_q <= y_q;
          if (y_q > acc_y_max_q) acc_y_max_q <= y_q;
        end
        if (acc_cnt_q != '1) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      end
    end
  end

  assign post_frame_vsync = vs_q;
  assign post_frame_href  = hs_q;
  assign post_frame_de    = de_q;
  assign skin_mask        = mask_q;
  assign bbox_x_min       = bx_min_q;
  assign bbox_x_max       = bx_max_q;
  assign bbox_y_min       = by_min_q;
  assign bbox_y_max       = by_max_q;
  assign skin_cnt         = cnt_q;
  assign bbox_valid       = valid_q;
  assign frame_done       = done_q;

endmodule
